// File: rtl/comparador_filtro_eventos.sv
// -----------------------------------------------------------------------------
// comparador_filtro_eventos
//
// Back-end for the comparator model's 1-bit decision. The raw decision is
// deglitched by a stability-count filter (FILT_LEN identical samples commit a
// transition). The block produces a clean level, one-cycle edge pulses and a
// saturating edge count. Each committed transition is offered as a timestamped
// event over a valid/ready handshake.
//
// Optional feature (compile-time macro COMPARADOR_FILTRO_SYNC_EN):
//   defined     - comp_i passes a 2-flop synchronizer (latency FILT_LEN + 2)
//   not defined - comp_i is sampled directly (latency FILT_LEN)
//
// Parameters:
//   FILT_LEN - consecutive identical samples needed to commit (1..255)
//   CNT_W    - edge counter width
//   TS_W     - free-running timestamp width
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         enables filter, timestamp and event generation
//   clr_i        synchronous clear of edge_cnt_o, evt_valid_o, evt_ovf_o
//   comp_i       raw comparator decision
//   comp_o       filtered level
//   rise_o       one-cycle pulse on committed 0->1
//   fall_o       one-cycle pulse on committed 1->0
//   edge_cnt_o   saturating count of committed transitions
//   evt_valid_o  event available
//   evt_ready_i  consumer accepts event
//   evt_rise_o   event polarity (1 = rising)
//   evt_ts_o     event timestamp
//   evt_ovf_o    sticky: an event was dropped
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module comparador_filtro_eventos #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TS_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             comp_i,
  output logic             comp_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic             evt_rise_o,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic             evt_ovf_o
);

  typedef enum logic [1:0] {StLow, StPendH, StHigh, StPendL} state_e;

  localparam logic [7:0]       FiltLenC = 8'(FILT_LEN);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  // ---------------------------------------------------------------------------
  // Sample selection
  // ---------------------------------------------------------------------------
  logic samp;

`ifdef COMPARADOR_FILTRO_SYNC_EN
  logic [1:0] sync_q;

  // Synchronizer runs regardless of en_i so it is settled when re-enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], comp_i};
    end
  end

  assign samp = sync_q[1];
`else
  assign samp = comp_i;
`endif

  // ---------------------------------------------------------------------------
  // Stability-count filter FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       commit_rise, commit_fall, commit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    if (en_i) begin
      unique case (state_q)
        StLow: begin
          if (samp) begin
            if (FiltLenC == 8'd1) begin
              state_d     = StHigh;
              commit_rise = 1'b1;
            end else begin
              state_d = StPendH;
              cnt_d   = 8'd1;
            end
          end
        end
        StPendH: begin
          if (samp) begin
            if (cnt_q + 8'd1 == FiltLenC) begin
              state_d     = StHigh;
              cnt_d       = '0;
              commit_rise = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            state_d = StLow;
            cnt_d   = '0;
          end
        end
        StHigh: begin
          if (!samp) begin
            if (FiltLenC == 8'd1) begin
              state_d     = StLow;
              commit_fall = 1'b1;
            end else begin
              state_d = StPendL;
              cnt_d   = 8'd1;
            end
          end
        end
        StPendL: begin
          if (!samp) begin
            if (cnt_q + 8'd1 == FiltLenC) begin
              state_d     = StLow;
              cnt_d       = '0;
              commit_fall = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            state_d = StHigh;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StLow;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign commit = commit_rise | commit_fall;

  // ---------------------------------------------------------------------------
  // Edge counter, timestamp and event register
  // ---------------------------------------------------------------------------
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_rise_q, evt_rise_d;
  logic [TS_W-1:0]  evt_ts_q, evt_ts_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             drain;

  assign drain = evt_valid_q & evt_ready_i;

  always_comb begin
    edge_cnt_d  = edge_cnt_q;
    ts_d        = ts_q;
    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    evt_ts_d    = evt_ts_q;
    evt_ovf_d   = evt_ovf_q;

    if (en_i) begin
      ts_d = ts_q + TS_W'(1);
    end

    if (clr_i) begin
      // Clear wins over a same-cycle commit: the event is discarded.
      edge_cnt_d  = '0;
      evt_valid_d = 1'b0;
      evt_ovf_d   = 1'b0;
    end else begin
      if (commit && (edge_cnt_q != CntMax)) begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
      if (commit) begin
        if (!evt_valid_q || drain) begin
          evt_valid_d = 1'b1;
          evt_rise_d  = commit_rise;
          evt_ts_d    = ts_q;  // value before this edge's increment
        end else begin
          evt_ovf_d = 1'b1;
        end
      end else if (drain) begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StLow;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      edge_cnt_q  <= '0;
      ts_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_rise_q  <= 1'b0;
      evt_ts_q    <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_q      <= commit_rise;
      fall_q      <= commit_fall;
      edge_cnt_q  <= edge_cnt_d;
      ts_q        <= ts_d;
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      evt_ts_q    <= evt_ts_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  // Level follows the committed state; pending states keep the old level.
  assign comp_o      = (state_q == StHigh) || (state_q == StPendL);
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign edge_cnt_o  = edge_cnt_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_rise_o  = evt_rise_q;
  assign evt_ts_o    = evt_ts_q;
  assign evt_ovf_o   = evt_ovf_q;

endmodule

// File: tb/tb_comparador_filtro_eventos.sv
// -----------------------------------------------------------------------------
// Testbench for comparador_filtro_eventos. Two instances share the stimulus:
// the default one (CNT_W = 16) and a CNT_W = 2 one for counter saturation.
// Expected values assume the synchronized input path; when the macro is not
// defined the bench delays comp_i by two cycles itself so the same vectors
// apply.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_comparador_filtro_eventos;

  localparam int unsigned FILT_LEN = 4;
  localparam int unsigned TS_W     = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic en_i = 1'b0;
  logic clr_i = 1'b0;
  logic comp_i = 1'b0;
  logic evt_ready_i = 1'b0;

  logic            comp_o, rise_o, fall_o, evt_valid_o, evt_rise_o, evt_ovf_o;
  logic [15:0]     edge_cnt_o;
  logic [TS_W-1:0] evt_ts_o;

  logic            s_comp_o, s_rise_o, s_fall_o, s_evt_valid_o, s_evt_rise_o, s_evt_ovf_o;
  logic [1:0]      s_edge_cnt_o;
  logic [TS_W-1:0] s_evt_ts_o;

  comparador_filtro_eventos #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (16),
    .TS_W    (TS_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .comp_i     (comp_i),
    .comp_o     (comp_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .edge_cnt_o (edge_cnt_o),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_rise_o (evt_rise_o),
    .evt_ts_o   (evt_ts_o),
    .evt_ovf_o  (evt_ovf_o)
  );

  comparador_filtro_eventos #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (2),
    .TS_W    (TS_W)
  ) dut_sat (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .comp_i     (comp_i),
    .comp_o     (s_comp_o),
    .rise_o     (s_rise_o),
    .fall_o     (s_fall_o),
    .edge_cnt_o (s_edge_cnt_o),
    .evt_valid_o(s_evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_rise_o (s_evt_rise_o),
    .evt_ts_o   (s_evt_ts_o),
    .evt_ovf_o  (s_evt_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   n;
    logic comp;
    logic ready;
    logic clr;
    logic e_comp;
    logic e_rise;
    logic e_fall;
    int   e_cnt;
    int   e_sat;
    logic e_valid;
    logic e_erise;
    int   e_ts;
    logic e_ovf;
  } vec_t;

  vec_t tbl[28];

`ifndef COMPARADOR_FILTRO_SYNC_EN
  logic [1:0] hist = 2'b00;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mimics the synchronizer latency when the DUT samples comp_i directly.
  task automatic drive_comp(input logic v);
`ifdef COMPARADOR_FILTRO_SYNC_EN
    comp_i = v;
`else
    comp_i  = hist[1];
    hist[1] = hist[0];
    hist[0] = v;
`endif
  endtask

  task automatic clear_comp_hist();
`ifndef COMPARADOR_FILTRO_SYNC_EN
    hist   = 2'b00;
    comp_i = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_comp, input logic e_rise,
                         input logic e_fall, input int e_cnt, input int e_sat,
                         input logic e_valid, input logic e_erise, input int e_ts,
                         input logic e_ovf);
    chk({tag, ".comp"},  32'(comp_o),       32'(e_comp));
    chk({tag, ".rise"},  32'(rise_o),       32'(e_rise));
    chk({tag, ".fall"},  32'(fall_o),       32'(e_fall));
    chk({tag, ".cnt"},   32'(edge_cnt_o),   32'(e_cnt));
    chk({tag, ".sat"},   32'(s_edge_cnt_o), 32'(e_sat));
    chk({tag, ".valid"}, 32'(evt_valid_o),  32'(e_valid));
    chk({tag, ".erise"}, 32'(evt_rise_o),   32'(e_erise));
    chk({tag, ".ts"},    32'(evt_ts_o),     32'(e_ts));
    chk({tag, ".ovf"},   32'(evt_ovf_o),    32'(e_ovf));
  endtask

  initial begin
    int row;
    //          n  cmp rdy clr | comp rise fall cnt sat valid erise ts  ovf
    tbl[0]  = '{5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0};  // filtering, no commit yet
    tbl[1]  = '{1, 1, 0, 0,  1, 1, 0, 1, 1, 1, 1, 5,  0};  // 6th edge: rise, ts 5
    tbl[2]  = '{5, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1, 5,  0};
    tbl[3]  = '{1, 0, 0, 0,  0, 0, 1, 2, 2, 1, 1, 5,  1};  // fall dropped, ovf
    tbl[4]  = '{1, 0, 1, 0,  0, 0, 0, 2, 2, 0, 1, 5,  1};  // first event drains
    tbl[5]  = '{3, 1, 0, 0,  0, 0, 0, 2, 2, 0, 1, 5,  1};  // 3-sample glitch
    tbl[6]  = '{4, 0, 0, 0,  0, 0, 0, 2, 2, 0, 1, 5,  1};
    tbl[7]  = '{1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 5,  0};  // clr
    tbl[8]  = '{5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 5,  0};
    tbl[9]  = '{1, 1, 0, 0,  1, 1, 0, 1, 1, 1, 1, 26, 0};
    tbl[10] = '{5, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1, 26, 0};
    tbl[11] = '{1, 0, 1, 0,  0, 0, 1, 2, 2, 1, 0, 32, 0};  // drain + commit together
    tbl[12] = '{1, 0, 0, 0,  0, 0, 0, 2, 2, 1, 0, 32, 0};
    tbl[13] = '{1, 0, 1, 0,  0, 0, 0, 2, 2, 0, 0, 32, 0};
    tbl[14] = '{4, 1, 1, 0,  0, 0, 0, 2, 2, 0, 0, 32, 0};
    tbl[15] = '{1, 0, 1, 0,  0, 0, 0, 2, 2, 0, 0, 32, 0};
    tbl[16] = '{1, 0, 1, 0,  1, 1, 0, 3, 3, 1, 1, 40, 0};
    tbl[17] = '{2, 0, 1, 0,  1, 0, 0, 3, 3, 0, 1, 40, 0};
    tbl[18] = '{1, 1, 1, 0,  1, 0, 0, 3, 3, 0, 1, 40, 0};
    tbl[19] = '{1, 1, 1, 0,  0, 0, 1, 4, 3, 1, 0, 44, 0};  // 2-bit count saturated
    tbl[20] = '{2, 1, 1, 0,  0, 0, 0, 4, 3, 0, 0, 44, 0};
    tbl[21] = '{1, 0, 1, 0,  0, 0, 0, 4, 3, 0, 0, 44, 0};
    tbl[22] = '{1, 0, 1, 0,  1, 1, 0, 5, 3, 1, 1, 48, 0};
    tbl[23] = '{2, 0, 1, 0,  1, 0, 0, 5, 3, 0, 1, 48, 0};
    tbl[24] = '{1, 0, 1, 0,  1, 0, 0, 5, 3, 0, 1, 48, 0};
    tbl[25] = '{1, 0, 1, 0,  0, 0, 1, 6, 3, 1, 0, 52, 0};
    tbl[26] = '{1, 0, 0, 0,  0, 0, 0, 6, 3, 1, 0, 52, 0};
    tbl[27] = '{1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 52, 0};  // clr after saturation

    // Reset state
    en_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;

    // Table-driven main sequence
    row = 0;
    for (int i = 0; i < 28; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        row++;
        drive_comp(tbl[i].comp);
        evt_ready_i = tbl[i].ready;
        clr_i       = tbl[i].clr;
        step();
        chk_all($sformatf("row%0d", row), tbl[i].e_comp, tbl[i].e_rise, tbl[i].e_fall,
                tbl[i].e_cnt, tbl[i].e_sat, tbl[i].e_valid, tbl[i].e_erise, tbl[i].e_ts,
                tbl[i].e_ovf);
      end
    end
    clr_i = 1'b0;
    evt_ready_i = 1'b0;

    // Asynchronous reset while pending high with cnt = 3
    for (int k = 0; k < 5; k++) begin
      drive_comp(1'b1);
      step();
    end
    chk("pend.comp", 32'(comp_o), 32'd0);
    chk("pend.ts_held", 32'(evt_ts_o), 32'd52);
    #3;
    rst_ni = 1'b0;
    clear_comp_hist();
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive_comp(1'b1);
      step();
      if (k < 6) begin
        chk($sformatf("rst_rel%0d.comp", k), 32'(comp_o), 32'd0);
      end else begin
        chk_all("rst_rel6", 1, 1, 0, 1, 1, 1, 1, 5, 0);
      end
    end

    // en_i = 0: frozen filter and timestamp, drain still works
    en_i = 1'b0;
    evt_ready_i = 1'b1;
    drive_comp(1'b0);
    step();
    chk("dis_drain.valid", 32'(evt_valid_o), 32'd0);
    chk("dis_drain.comp", 32'(comp_o), 32'd1);
    evt_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_comp(1'b0);
      step();
      chk($sformatf("dis%0d.comp", k), 32'(comp_o), 32'd1);
      chk($sformatf("dis%0d.fall", k), 32'(fall_o), 32'd0);
    end
    en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive_comp(1'b0);
      step();
      if (k < 4) begin
        chk($sformatf("reen%0d.comp", k), 32'(comp_o), 32'd1);
      end else begin
        chk_all("reen4", 0, 0, 1, 2, 2, 1, 0, 9, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
